// File: rtl/led_arbiter_if.sv
// led_arbiter_if: request/data/grant bundle shared by LED requesters and led_arbiter.
// master = requester side, slave = arbiter side.
interface led_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [7:0]        leds;

  modport master (
    output req,
    output data,
    input  grant,
    input  busy,
    input  leds
  );

  modport slave (
    input  req,
    input  data,
    output grant,
    output busy,
    output leds
  );
endinterface

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin ownership of a shared 8-bit LED bank, one IDLE cycle between grants.
// Optional preemption after MAX_HOLD owned cycles is enabled by defining LED_ARBITER_PREEMPT_EN.
module led_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         MAX_HOLD = 8,
  parameter logic [7:0] IDLE_PAT = 8'b10101010
) (
  input  logic         clock,
  input  logic         resetn,
  led_arbiter_if.slave arb_io
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 2) begin : g_paramCheck
    $error("led_arbiter: NREQ must be 2..8 and MAX_HOLD must be >= 2");
  end

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic [7:0]              leds_q, leds_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [PTR_W-1:0]        pick, idx;
  logic                    found;
  logic                    releaseNow;
  logic                    preemptNow;
  logic [NREQ-1:0][7:0]    dataVec;

  assign dataVec = arb_io.data;

`ifdef LED_ARBITER_PREEMPT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_q, hold_d;

  assign preemptNow = (hold_q == HOLD_MAX) && (|(arb_io.req & ~grant_q));
`else
  assign preemptNow = 1'b0;
`endif

  // First active request at or after ptr, wrapping around.
  always_comb begin : search
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!found && arb_io.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin : nextState
    state_d    = state_q;
    grant_d    = grant_q;
    leds_d     = leds_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    releaseNow = 1'b0;
`ifdef LED_ARBITER_PREEMPT_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          grant_d = NREQ'(1) << pick;
          owner_d = pick;
`ifdef LED_ARBITER_PREEMPT_EN
          hold_d  = '0;
`endif
        end
      end
      OWNED: begin
        // A releasing or preempted owner's data is no longer trusted, so leds hold.
        releaseNow = !arb_io.req[owner_q] || preemptNow;
        if (releaseNow) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end else begin
          leds_d = dataVec[owner_q];
`ifdef LED_ARBITER_PREEMPT_EN
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      leds_q  <= IDLE_PAT;
      ptr_q   <= '0;
      owner_q <= '0;
`ifdef LED_ARBITER_PREEMPT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      leds_q  <= leds_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
`ifdef LED_ARBITER_PREEMPT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign arb_io.grant = grant_q;
  assign arb_io.busy  = busy_q;
  assign arb_io.leds  = leds_q;
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: vector table, hand-written corner sequences and a randomized run
// checked against a spec-level ownership model of led_arbiter.
module tb_led_arbiter;
  localparam int         NREQ     = 4;
  localparam int         MAX_HOLD = 8;
  localparam logic [7:0] IDLE_PAT = 8'hAA;

  logic clock = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  led_arbiter_if #(.NREQ(NREQ)) bus ();

  led_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD),
    .IDLE_PAT (IDLE_PAT)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .arb_io (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        leds;
  } vec_t;

  vec_t vecs[$];

  // Reference model: who owns the bank, where the search resumes, what is shown.
  int         mOwner;
  int         mPtr;
  int         mOwnedEdges;
  logic [7:0] mLeds;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [NREQ-1:0] eg,
                          input logic eb, input logic [7:0] el);
    checkOutput({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    checkOutput({tag, ".busy"},  32'(bus.busy),  32'(eb));
    checkOutput({tag, ".leds"},  32'(bus.leds),  32'(el));
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] d);
    bus.req  = r;
    bus.data = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic modelReset();
    mOwner      = -1;
    mPtr        = 0;
    mOwnedEdges = 0;
    mLeds       = IDLE_PAT;
  endtask

  task automatic modelStep();
    logic [NREQ-1:0]   r;
    logic [8*NREQ-1:0] d;
    bit                revoke;
    r = bus.req;
    d = bus.data;
    if (mOwner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (mOwner < 0 && ((r >> ((mPtr + k) % NREQ)) & 1) != 0) begin
          mOwner      = (mPtr + k) % NREQ;
          mOwnedEdges = 0;
        end
      end
    end else begin
      revoke = ((r >> mOwner) & 1) == 0;
`ifdef LED_ARBITER_PREEMPT_EN
      if (mOwnedEdges >= MAX_HOLD && (r & ~(NREQ'(1) << mOwner)) != '0) revoke = 1'b1;
`endif
      if (revoke) begin
        mPtr   = (mOwner + 1) % NREQ;
        mOwner = -1;
      end else begin
        mLeds = 8'(d >> (8 * mOwner));
        mOwnedEdges++;
      end
    end
  endtask

  function automatic logic [NREQ-1:0] modelGrant();
    return (mOwner < 0) ? '0 : (NREQ'(1) << mOwner);
  endfunction

  // Asynchronous reset pulse checked between clock edges, released 1 ns after an edge.
  task automatic doReset(input string tag);
    resetn = 1'b1;
    #1;
    resetn = 1'b0;
    #2;
    checkAll(tag, '0, 1'b0, IDLE_PAT);
    applyStimulus('0, '0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    modelReset();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NREQ-1:0]   r;
    logic [8*NREQ-1:0] d;
    int                holdCnt;

    applyStimulus('0, '0);
    resetn = 1'b1;

    // Reset values, then ten idle cycles with no request.
    doReset("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      checkAll($sformatf("idle%0d", i), '0, 1'b0, IDLE_PAT);
    end

    // Vector table, data packed as {d3,d2,d1,d0}.
    vecs.push_back('{4'b0001, 32'h1122335A, 4'b0001, 1'b1, 8'hAA});
    vecs.push_back('{4'b0001, 32'h1122335A, 4'b0001, 1'b1, 8'h5A});
    vecs.push_back('{4'b0011, 32'h1122333C, 4'b0001, 1'b1, 8'h3C});
    vecs.push_back('{4'b0010, 32'h112299C3, 4'b0000, 1'b0, 8'h3C});
    vecs.push_back('{4'b0010, 32'h112299C3, 4'b0010, 1'b1, 8'h3C});
    vecs.push_back('{4'b0010, 32'h112299C3, 4'b0010, 1'b1, 8'h99});
    vecs.push_back('{4'b1100, 32'hD3D26601, 4'b0000, 1'b0, 8'h99});
    vecs.push_back('{4'b1100, 32'hD3D26601, 4'b0100, 1'b1, 8'h99});
    vecs.push_back('{4'b1100, 32'hD3E26601, 4'b0100, 1'b1, 8'hE2});
    vecs.push_back('{4'b1000, 32'hF3E26601, 4'b0000, 1'b0, 8'hE2});
    vecs.push_back('{4'b1001, 32'hF3E26601, 4'b1000, 1'b1, 8'hE2});
    vecs.push_back('{4'b1001, 32'hF3E26601, 4'b1000, 1'b1, 8'hF3});
    vecs.push_back('{4'b0001, 32'h0FE26601, 4'b0000, 1'b0, 8'hF3});
    vecs.push_back('{4'b0001, 32'h0FE26601, 4'b0001, 1'b1, 8'hF3});
    vecs.push_back('{4'b0000, 32'h0FE26677, 4'b0000, 1'b0, 8'hF3});
    vecs.push_back('{4'b0000, 32'h0FE26655, 4'b0000, 1'b0, 8'hF3});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].data);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].leds);
    end

    // Round robin from reset: each owner drops after three owned cycles.
    doReset("rr.reset");
    r = 4'b1111;
    applyStimulus(r, 32'h44332211);
    for (int o = 0; o < NREQ; o++) begin
      tick();
      checkOutput($sformatf("rr.grant%0d", o), 32'(bus.grant), 32'(NREQ'(1) << o));
      tick();
      tick();
      checkOutput($sformatf("rr.hold%0d", o), 32'(bus.grant), 32'(NREQ'(1) << o));
      r = r & ~(NREQ'(1) << o);
      applyStimulus(r, 32'h44332211);
      tick();
      checkOutput($sformatf("rr.idle%0d", o), 32'(bus.grant), 32'h0);
    end
    checkOutput("rr.leds", 32'(bus.leds), 32'h44);

    // Reset while requester 2 owns the bank.
    doReset("mid.reset");
    applyStimulus(4'b0100, 32'h00C40000);
    tick();
    checkOutput("mid.grant", 32'(bus.grant), 32'b0100);
    tick();
    checkOutput("mid.leds", 32'(bus.leds), 32'hC4);
    resetn = 1'b0;
    #2;
    checkAll("mid.async", '0, 1'b0, IDLE_PAT);
    applyStimulus(4'b0110, 32'h00C4B100);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    tick();
    checkOutput("mid.next", 32'(bus.grant), 32'b0010);

`ifdef LED_ARBITER_PREEMPT_EN
    // Requester 1 arrives two cycles into grant 0; revoke once MAX_HOLD owned edges elapsed.
    doReset("pre.reset");
    applyStimulus(4'b0001, 32'h0000BB0A);
    tick();
    checkOutput("pre.grant0", 32'(bus.grant), 32'b0001);
    tick();
    tick();
    applyStimulus(4'b0011, 32'h0000BB0A);
    for (int e = 3; e <= MAX_HOLD; e++) begin
      tick();
      checkOutput($sformatf("pre.hold%0d", e), 32'(bus.grant), 32'b0001);
    end
    tick();
    checkOutput("pre.revoke", 32'(bus.grant), 32'h0);
    tick();
    checkOutput("pre.grant1", 32'(bus.grant), 32'b0010);
`else
    // Without preemption the owner keeps the bank for as long as it requests.
    doReset("nopre.reset");
    applyStimulus(4'b0011, 32'h0000BB0A);
    tick();
    checkOutput("nopre.grant0", 32'(bus.grant), 32'b0001);
    holdCnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.grant == 4'b0001) holdCnt++;
    end
    checkOutput("nopre.hold100", 32'(holdCnt), 32'd100);
    applyStimulus(4'b0010, 32'h0000BB0A);
    tick();
    checkOutput("nopre.release", 32'(bus.grant), 32'h0);
    tick();
    checkOutput("nopre.grant1", 32'(bus.grant), 32'b0010);
`endif

    // Randomized requests with sticky levels, compared against the model.
    doReset("rand.reset");
    r = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(5) == 0) r = r ^ (NREQ'(1) << b);
      end
      d = 32'($urandom);
      applyStimulus(r, d);
      @(posedge clock);
      modelStep();
      #1;
      checkAll($sformatf("rand%0d", cyc), modelGrant(), mOwner >= 0, mLeds);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the LED bank (2..8).
REQ-002 Parameter MAX_HOLD, default 8: clock cycles one grant may last while another requester waits (>=2).
REQ-003 Parameter IDLE_PAT, default 8'b10101010: LED pattern driven after reset.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request level; held high for as long as the requester wants the LEDs.
REQ-007 data  input  8*NREQ  per-requester LED value; requester i uses bits [8i+7:8i].
REQ-008 grant  output  NREQ  one-hot (or all-zero) ownership indication, registered.
REQ-009 busy  output  1  high while any grant bit is high, registered.
REQ-010 leds  output  8  shared LED bank, registered.

Function
REQ-011 The block SHALL have two states: IDLE (grant=0) and OWNED (exactly one grant bit high).
REQ-012 In IDLE, with any req bit high, the next edge SHALL enter OWNED, granting the first requester with req high, searching circularly from pointer ptr.
REQ-013 In IDLE with req=0, the block SHALL stay in IDLE, and leds and ptr SHALL hold.
REQ-014 In OWNED, leds SHALL load data of the owner on every edge (one-cycle latency from data to leds).
REQ-015 In OWNED, when req[owner] is sampled low, the next edge SHALL clear grant, enter IDLE, and set ptr=(owner+1) mod NREQ; leds SHALL keep the last value.
REQ-016 Between two grants there SHALL be at least one IDLE cycle; grant SHALL never change directly from one owner to another.
REQ-017 A hold counter (width clog2(MAX_HOLD+1)) SHALL clear on entry to OWNED, increment each OWNED cycle, and saturate at MAX_HOLD.
REQ-018 Data of non-owners SHALL never reach leds.
REQ-019 busy SHALL equal the OR of grant bits at all times.

Reset
REQ-020 Asserting resetn low SHALL immediately force grant=0, busy=0, leds=IDLE_PAT, state=IDLE, ptr=0, and hold counter=0, including mid-grant.
REQ-021 After resetn is released, the first grant SHALL occur no earlier than the first edge at which req is sampled nonzero.

Configuration
REQ-022 Macro LED_ARBITER_PREEMPT_EN SHALL control preemption.
- Defined: when the hold counter equals MAX_HOLD and any other req bit is high, the next edge SHALL revoke the grant (as in REQ-015, ptr=owner+1).
- Defined: if no other requester is waiting, the grant SHALL persist with the counter saturated.
- Not defined: a grant SHALL last until the owner drops req; the hold counter SHALL be omitted.
REQ-023 If the owner drops req in the same cycle that preemption fires, the block SHALL treat it as a normal release, with an identical result.

Verification (NREQ=4, MAX_HOLD=8)
REQ-024 Reset: assert resetn=0 -> leds=8'hAA, grant=4'b0000, busy=0; after release, hold req=0 for 10 cycles -> outputs unchanged.
REQ-025 Single request: req=4'b0001 and data0=8'h5A sampled at edge N -> grant=4'b0001 after edge N, leds=8'h5A after edge N+1; req0 low -> grant=0 next edge, leds stays 8'h5A.
REQ-026 Round-robin: req=4'b1111 from reset, each owner dropping req 3 cycles after its grant -> grant order 0001, 0010, 0100, 1000, each separated by exactly one IDLE cycle.
REQ-027 Preemption (macro defined): req0 held, req1 raised 2 cycles into grant0 -> grant0 revoked after the MAX_HOLD-th OWNED cycle; one IDLE cycle follows; then grant=4'b0010.
REQ-028 No preemption (macro undefined): req0 held 100 cycles with req1 high -> grant stays 4'b0001 throughout; grant1 follows 2 edges after req0 falls.
REQ-029 Reset mid-grant: resetn low for 1 cycle while grant=4'b0100 -> grant=0 and leds=8'hAA without waiting for a clock edge; with req=4'b0110 still high after release, the next grant is 4'b0010 (ptr=0).
